// File: rtl/banked_sdp_bram.sv
// banked_sdp_bram: simple-dual-port memory built from fixed-size banks.
// One write port and one independent read port, both on clk.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset (clears the read pipeline and the error flags)
//   wr_en     write request; wr_addr / wr_data / wr_be carry the word address, data, byte enables
//   wr_err    one-cycle pulse: the previous-cycle write was out of range and was dropped
//   rd_en     read request; rd_addr is the word address
//   rd_data   read data, qualified by rd_valid (it holds while rd_valid is low)
//   rd_valid  read result strobe, 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles after rd_en
//   rd_err    high with rd_valid when that read was out of range (rd_data is then 0)
module banked_sdp_bram #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WORDS      = 19200,
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned BANK_WORDS     = 1024,
  parameter int unsigned OUT_REG        = 1,
  parameter int unsigned COLLISION_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    wr_err,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_err
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W     = $clog2(BANK_WORDS);
  localparam int unsigned SEL_W     = ADDR_WIDTH - OFF_W;
  localparam int unsigned NUM_BANKS = (NUM_WORDS + BANK_WORDS - 1) / BANK_WORDS;
  localparam bit          WRITE_FIRST = (COLLISION_MODE == 0);
  // One extra bit so NUM_WORDS == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(NUM_WORDS);

  // Address decode
  logic [SEL_W-1:0] wr_sel, rd_sel;
  logic [OFF_W-1:0] wr_off, rd_off;
  logic             wr_ok, rd_ok, wr_go, rd_go, coll;

  assign wr_sel = wr_addr[ADDR_WIDTH-1:OFF_W];
  assign rd_sel = rd_addr[ADDR_WIDTH-1:OFF_W];
  assign wr_off = wr_addr[OFF_W-1:0];
  assign rd_off = rd_addr[OFF_W-1:0];
  assign wr_ok  = ({1'b0, wr_addr} < LIMIT);
  assign rd_ok  = ({1'b0, rd_addr} < LIMIT);
  assign wr_go  = wr_en & wr_ok;
  assign rd_go  = rd_en & rd_ok;
  assign coll   = wr_go & rd_go & (wr_addr == rd_addr);

  // Banks: each holds its own registered read word; only the addressed bank
  // is enabled, so idle banks keep their last read value.
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  wr_hit, rd_hit;

    assign wr_hit = wr_go & (wr_sel == SEL_W'(b));
    assign rd_hit = rd_go & (rd_sel == SEL_W'(b));

    // Read sees the pre-write word on a same-address collision (read-first
    // array); write-first results are patched in after the array.
    always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_hit && wr_be[i]) begin
          mem[wr_off][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
      if (rd_hit) begin
        rdata_q <= mem[rd_off];
      end
    end

    assign bank_rdata[b] = rdata_q;
  end

  // Read stage 1: request tracking alongside the array access.
  // s1_oor_q resets to 1 so the unregistered output path reads as zero after
  // reset; rd_err is always gated by the valid bit.
  logic                  s1_valid_q;
  logic                  s1_oor_q;
  logic [SEL_W-1:0]      s1_bank_q;
  logic                  coll_q;
  logic [NUM_BYTES-1:0]  coll_be_q;
  logic [DATA_WIDTH-1:0] coll_data_q;
  logic [DATA_WIDTH-1:0] s1_raw;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_oor_q    <= 1'b1;
      s1_bank_q   <= '0;
      coll_q      <= 1'b0;
      coll_be_q   <= '0;
      coll_data_q <= '0;
    end else begin
      s1_valid_q <= rd_en;
      // Everything else only moves on a request so the output holds between reads.
      if (rd_en) begin
        s1_oor_q    <= ~rd_ok;
        s1_bank_q   <= rd_sel;
        coll_q      <= coll;
        coll_be_q   <= wr_be;
        coll_data_q <= wr_data;
      end
    end
  end

  always_comb begin
    s1_raw = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (s1_bank_q == SEL_W'(b)) begin
        s1_raw = bank_rdata[b];
      end
    end
    s1_data = s1_raw;
    if (WRITE_FIRST && coll_q) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (coll_be_q[i]) begin
          s1_data[8*i +: 8] = coll_data_q[8*i +: 8];
        end
      end
    end
    if (s1_oor_q) begin
      s1_data = '0;
    end
  end

  // Output stage
  if (OUT_REG != 0) begin : g_out_reg
    logic                  valid_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          err_q  <= s1_oor_q;
          data_q <= s1_data;
        end
      end
    end

    assign rd_valid = valid_q;
    assign rd_data  = data_q;
    assign rd_err   = valid_q & err_q;
  end else begin : g_no_out_reg
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data;
    assign rd_err   = s1_valid_q & s1_oor_q;
  end

  // Write error pulse
  logic wr_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en & ~wr_ok;
    end
  end

  assign wr_err = wr_err_q;

endmodule
